// File: rtl/adc_seq_pkg.sv
// Shared widths, constants and FSM encoding for the ADC channel sequencer.
package adc_seq_pkg;

    localparam int ADC_CODE_W    = 12;
    localparam int MV_W          = 13;
    localparam int CH_W          = 5;
    localparam int ADC_FULL_CODE = 4095;
    localparam int NUM_W         = 25;
    localparam int DIV_STEPS     = 25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_ISSUE,
        ST_AWAIT_RSP,
        ST_SCALE,
        ST_NEXT
    } seq_state_t;

endpackage

// File: rtl/adc_mv_scaler.sv
// Converts a 12-bit ADC code to millivolts: floor(code*FULL_MV/4095),
// one multiply at start then a fixed 25-step restoring divide.
module adc_mv_scaler
    import adc_seq_pkg::*;
#(
    parameter int FULL_MV = 5000
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [ADC_CODE_W-1:0] i_code,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [MV_W-1:0]       o_mv
);

    localparam logic [MV_W-1:0] DIVISOR = MV_W'(ADC_FULL_CODE);

    logic [NUM_W-1:0]      r_num;
    logic [MV_W-1:0]       r_quo;
    logic [ADC_CODE_W-1:0] r_rem;
    logic [4:0]            r_step;
    logic                  r_busy;
    logic                  r_done;

    logic [MV_W-1:0]       w_rem_sh;
    logic                  w_fit;

    // Only the low MV_W quotient bits are kept: the final result never exceeds FULL_MV.
    assign w_rem_sh = {r_rem, r_num[NUM_W-1]};
    assign w_fit    = (w_rem_sh >= DIVISOR);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_num  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_step <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_num  <= NUM_W'(i_code) * NUM_W'(FULL_MV);
                r_quo  <= '0;
                r_rem  <= '0;
                r_step <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_num  <= {r_num[NUM_W-2:0], 1'b0};
                r_rem  <= ADC_CODE_W'(w_fit ? (w_rem_sh - DIVISOR) : w_rem_sh);
                r_quo  <= {r_quo[MV_W-2:0], w_fit};
                r_step <= r_step + 5'd1;
                if (r_step == 5'(DIV_STEPS - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_mv   = r_quo;

endmodule

// File: rtl/adc_channel_sequencer.sv
// Round-robin command/response sequencer for the modular ADC: issues one
// command per slot, scales each matched response to mV and keeps a result bank.
module adc_channel_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int FIRST_CH  = 1,
    parameter int SWEEP_DIV = 5000,
    parameter int TIMEOUT   = 1023,
    parameter int FULL_MV   = 5000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  cmd_valid,
    output logic [CH_W-1:0]       cmd_channel,
    output logic                  cmd_sop,
    output logic                  cmd_eop,
    input  logic                  cmd_ready,
    input  logic                  rsp_valid,
    input  logic [CH_W-1:0]       rsp_channel,
    input  logic [ADC_CODE_W-1:0] rsp_data,
    input  logic [2:0]            rd_sel,
    output logic [MV_W-1:0]       rd_mv,
    output logic                  sample_valid,
    output logic [2:0]            sample_slot,
    output logic [MV_W-1:0]       sample_mv,
    output logic                  sweep_done,
    output logic                  timeout_err,
    output logic                  chan_err
);

    localparam int SW_W = $clog2(SWEEP_DIV);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [2:0] LAST_SLOT = 3'(NUM_CH - 1);

    seq_state_t      r_state;
    seq_state_t      w_next;

    logic [2:0]      r_slot;
    logic [SW_W-1:0] r_sweep_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [MV_W-1:0] r_bank [8];
    logic            r_sample_valid;
    logic [2:0]      r_sample_slot;
    logic [MV_W-1:0] r_sample_mv;
    logic            r_sweep_done;
    logic            r_timeout_err;
    logic            r_chan_err;

    logic [CH_W-1:0] w_exp_ch;
    logic            w_tick;
    logic            w_last;
    logic            w_to_hit;
    logic            w_start;
    logic            w_bank_we;
    logic            w_slot_inc;
    logic            w_slot_clr;
    logic            w_done_pulse;
    logic            w_set_to;
    logic            w_rsp_stray;
    logic            w_div_busy;
    logic            w_div_done;
    logic [MV_W-1:0] w_div_mv;

    assign w_exp_ch = CH_W'(FIRST_CH) + CH_W'(r_slot);
    assign w_tick   = (r_sweep_cnt == SW_W'(SWEEP_DIV - 1));
    assign w_last   = (r_slot == LAST_SLOT);
    assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        w_bank_we    = 1'b0;
        w_slot_inc   = 1'b0;
        w_slot_clr   = 1'b0;
        w_done_pulse = 1'b0;
        w_set_to     = 1'b0;
        w_rsp_stray  = rsp_valid;
        cmd_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_slot_clr = 1'b1;
                    w_next     = ST_ISSUE;
                end
            end
            ST_WAIT_TICK: begin
                if (!enable)     w_next = ST_IDLE;
                else if (w_tick) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) w_next = ST_AWAIT_RSP;
            end
            ST_AWAIT_RSP: begin
                // A matching response wins over a timeout landing on the same cycle.
                if (rsp_valid && (rsp_channel == w_exp_ch) && !w_div_busy) begin
                    w_rsp_stray = 1'b0;
                    w_start     = 1'b1;
                    w_next      = ST_SCALE;
                end else if (w_to_hit) begin
                    w_set_to = 1'b1;
                    w_next   = ST_NEXT;
                end
            end
            ST_SCALE: begin
                if (w_div_done) begin
                    w_bank_we = 1'b1;
                    w_next    = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (enable && !w_last) begin
                    w_slot_inc = 1'b1;
                    w_next     = ST_ISSUE;
                end else begin
                    w_slot_clr   = 1'b1;
                    w_done_pulse = w_last;
                    w_next       = enable ? ST_WAIT_TICK : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_slot         <= '0;
            r_sweep_cnt    <= '0;
            r_to_cnt       <= '0;
            r_bank         <= '{default: '0};
            r_sample_valid <= 1'b0;
            r_sample_slot  <= '0;
            r_sample_mv    <= '0;
            r_sweep_done   <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_chan_err     <= 1'b0;
        end else begin
            r_sample_valid <= w_bank_we;
            r_sweep_done   <= w_done_pulse;

            if (w_slot_clr)      r_slot <= '0;
            else if (w_slot_inc) r_slot <= r_slot + 3'd1;

            // Held at zero in IDLE so the first sweep after enable starts a fresh period.
            if ((r_state == ST_IDLE) || w_tick) r_sweep_cnt <= '0;
            else                                r_sweep_cnt <= r_sweep_cnt + SW_W'(1);

            if (r_state == ST_AWAIT_RSP) r_to_cnt <= r_to_cnt + TO_W'(1);
            else                         r_to_cnt <= '0;

            if (w_bank_we) begin
                r_bank[r_slot] <= w_div_mv;
                r_sample_slot  <= r_slot;
                r_sample_mv    <= w_div_mv;
            end

            if (w_set_to)    r_timeout_err <= 1'b1;
            if (w_rsp_stray) r_chan_err    <= 1'b1;
        end
    end

    adc_mv_scaler #(
        .FULL_MV (FULL_MV)
    ) u_scaler (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_start   (w_start),
        .i_code    (rsp_data),
        .o_busy    (w_div_busy),
        .o_done    (w_div_done),
        .o_mv      (w_div_mv)
    );

    assign cmd_channel  = cmd_valid ? w_exp_ch : '0;
    assign cmd_sop      = cmd_valid;
    assign cmd_eop      = cmd_valid;
    assign rd_mv        = (rd_sel <= LAST_SLOT) ? r_bank[rd_sel] : '0;
    assign sample_valid = r_sample_valid;
    assign sample_slot  = r_sample_slot;
    assign sample_mv    = r_sample_mv;
    assign sweep_done   = r_sweep_done;
    assign timeout_err  = r_timeout_err;
    assign chan_err     = r_chan_err;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Directed bench for adc_channel_sequencer with an ADC response model and a
// scoreboard of expected (slot, mV) results.
module tb_adc_channel_sequencer;

    localparam int FULL = 5000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        cmd_valid;
    logic [4:0]  cmd_channel;
    logic        cmd_sop;
    logic        cmd_eop;
    logic        cmd_ready = 1'b1;
    logic        rsp_valid = 1'b0;
    logic [4:0]  rsp_channel = '0;
    logic [11:0] rsp_data = '0;
    logic [2:0]  rd_sel = '0;
    logic [12:0] rd_mv;
    logic        sample_valid;
    logic [2:0]  sample_slot;
    logic [12:0] sample_mv;
    logic        sweep_done;
    logic        timeout_err;
    logic        chan_err;

    adc_channel_sequencer #(
        .NUM_CH    (4),
        .FIRST_CH  (1),
        .SWEEP_DIV (400),
        .TIMEOUT   (1023),
        .FULL_MV   (FULL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .cmd_valid    (cmd_valid),
        .cmd_channel  (cmd_channel),
        .cmd_sop      (cmd_sop),
        .cmd_eop      (cmd_eop),
        .cmd_ready    (cmd_ready),
        .rsp_valid    (rsp_valid),
        .rsp_channel  (rsp_channel),
        .rsp_data     (rsp_data),
        .rd_sel       (rd_sel),
        .rd_mv        (rd_mv),
        .sample_valid (sample_valid),
        .sample_slot  (sample_slot),
        .sample_mv    (sample_mv),
        .sweep_done   (sweep_done),
        .timeout_err  (timeout_err),
        .chan_err     (chan_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    int cyc = 0;
    int n_cmd = 0;
    int n_done = 0;
    int n_xfer_ch [32];
    int code_tab [32];
    int drop_ch = 0;
    int wrong_ch = 0;
    int pend = 0;
    int pend_ch = 0;
    int wrong_cnt = 0;

    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    int          t1_q [$];

    always @(posedge clk) cyc++;

    function automatic int mv_of(input int code);
        return (code * FULL) / 4095;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // ADC model: answers each accepted command a few cycles later.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            rsp_valid = 1'b0;
            if (!reset_n) begin
                pend      = 0;
                wrong_cnt = 0;
            end else begin
                if (wrong_cnt > 0) begin
                    wrong_cnt--;
                    if (wrong_cnt == 0) begin
                        rsp_valid   = 1'b1;
                        rsp_channel = 5'd7;
                        rsp_data    = 12'd77;
                    end
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        rsp_valid   = 1'b1;
                        rsp_channel = 5'(pend_ch);
                        rsp_data    = 12'(code_tab[pend_ch]);
                        exp_q.push_back({3'(pend_ch - 1), 13'(mv_of(code_tab[pend_ch]))});
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    n_cmd++;
                    n_xfer_ch[cmd_channel]++;
                    if (cmd_channel == 5'd1) t1_q.push_back(cyc);
                    if (int'(cmd_channel) != drop_ch) begin
                        pend_ch = int'(cmd_channel);
                        if (pend_ch == wrong_ch) begin
                            wrong_cnt = 2;
                            pend      = 6;
                        end else begin
                            pend = 4;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sample_valid) got_q.push_back({sample_slot, sample_mv});
            if (sweep_done) n_done++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic wait_cmd(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cmd_valid) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    task automatic wait_sample(input string tag);
        logic        found;
        logic [15:0] g;
        logic [15:0] e;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (got_q.size() > 0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            #3;
        end
        check({tag, "_arrived"}, 32'(found), 32'd1);
        if (found) begin
            g = got_q.pop_front();
            if (exp_q.size() == 0) begin
                check({tag, "_expected_pending"}, 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_slot"}, 32'(g[15:13]), 32'(e[15:13]));
                check({tag, "_mv"}, 32'(g[12:0]), 32'(e[12:0]));
            end
        end
    endtask

    task automatic wait_done(input int n, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #3;
            if (n_done >= n) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic check_rd(input int sel, input int expv, input string tag);
        rd_sel = 3'(sel);
        #1;
        check(tag, 32'(rd_mv), 32'(expv));
    endtask

    initial begin
        int ch3_before;
        int cmds;
        logic ok;

        foreach (n_xfer_ch[i]) n_xfer_ch[i] = 0;
        foreach (code_tab[i]) code_tab[i] = 0;
        code_tab[1] = 0;
        code_tab[2] = 1000;
        code_tab[3] = 2048;
        code_tab[4] = 4095;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_valid", 32'(cmd_valid), 0);
        check("rst_sample_valid", 32'(sample_valid), 0);
        check("rst_sweep_done", 32'(sweep_done), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_chan_err", 32'(chan_err), 0);
        check_rd(0, 0, "rst_rd0");
        reset_n = 1'b1;

        // Basic sweep, two sweeps back to back
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) wait_sample($sformatf("sw1_s%0d", k));
        wait_done(1, "sw1_done");
        check("sw1_done_count", 32'(n_done), 1);
        for (int k = 0; k < 4; k++) check_rd(k, mv_of(code_tab[k + 1]), $sformatf("sw1_rd%0d", k));
        check_rd(4, 0, "rd_out_of_range4");
        check_rd(7, 0, "rd_out_of_range7");
        for (int k = 0; k < 4; k++) wait_sample($sformatf("sw2_s%0d", k));
        wait_done(2, "sw2_done");
        check("sweep_period", 32'(t1_q.size() >= 2 ? t1_q[1] - t1_q[0] : -1), 32'd400);

        // Back-pressure: hold cmd_ready low while slot 2 is offered
        cmd_ready  = 1'b0;
        ch3_before = n_xfer_ch[3];
        for (int k = 1; k <= 4; k++) begin
            wait_cmd($sformatf("bp_cmd%0d", k));
            check($sformatf("bp_chan%0d", k), 32'(cmd_channel), 32'(k));
            if (k == 3) begin
                ok = 1'b1;
                repeat (7) begin
                    @(negedge clk);
                    if (!(cmd_valid === 1'b1 && cmd_channel === 5'd3)) ok = 1'b0;
                end
                check("bp_hold_stable", 32'(ok), 1);
            end
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
            check($sformatf("bp_dropped%0d", k), 32'(cmd_valid), 0);
        end
        cmd_ready = 1'b1;
        #3;
        check("bp_ch3_xfers", 32'(n_xfer_ch[3] - ch3_before), 1);
        for (int k = 0; k < 4; k++) wait_sample($sformatf("bp_s%0d", k));
        wait_done(3, "bp_done");

        // Timeout on channel 2
        drop_ch = 2;
        wait_cmd("to_cmd1");
        check("to_chan1", 32'(cmd_channel), 1);
        wait_cmd("to_cmd2");
        check("to_chan2", 32'(cmd_channel), 2);
        check("to_err_before", 32'(timeout_err), 0);
        repeat (1023) @(negedge clk);
        check("to_err_not_yet", 32'(timeout_err), 0);
        @(negedge clk);
        check("to_err_set", 32'(timeout_err), 1);
        check_rd(1, mv_of(1000), "to_bank1_kept");
        wait_cmd("to_cmd3");
        check("to_next_chan", 32'(cmd_channel), 3);
        drop_ch = 0;
        for (int k = 0; k < 3; k++) wait_sample($sformatf("to_s%0d", k));
        wait_done(4, "to_done");

        // Wrong-channel response before the real one
        code_tab[1] = 2048;
        wrong_ch    = 1;
        check("ce_before", 32'(chan_err), 0);
        wait_cmd("ce_cmd1");
        check("ce_chan1", 32'(cmd_channel), 1);
        wait_sample("ce_s0");
        wrong_ch = 0;
        check("ce_set", 32'(chan_err), 1);
        check_rd(0, 2500, "ce_bank0");
        for (int k = 1; k < 4; k++) wait_sample($sformatf("ce_s%0d", k));
        wait_done(5, "ce_done");

        // Drop enable while slot 1 is in flight
        wait_cmd("en_cmd1");
        check("en_chan1", 32'(cmd_channel), 1);
        wait_cmd("en_cmd2");
        check("en_chan2", 32'(cmd_channel), 2);
        enable = 1'b0;
        wait_sample("en_s0");
        wait_sample("en_s1");
        cmds = n_cmd;
        repeat (600) @(negedge clk);
        #3;
        check("en_no_more_cmds", 32'(n_cmd - cmds), 0);
        check("en_no_more_samples", 32'(got_q.size()), 0);
        check("en_no_sweep_done", 32'(n_done), 5);
        check("en_idle_cmd_valid", 32'(cmd_valid), 0);

        // Reset while the divider is running
        enable = 1'b1;
        wait_cmd("rs_cmd1");
        check("rs_chan1", 32'(cmd_channel), 1);
        repeat (13) @(negedge clk);
        reset_n = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        exp_q.delete();
        check("rs_cmd_valid", 32'(cmd_valid), 0);
        check("rs_sample_valid", 32'(sample_valid), 0);
        check("rs_sample_mv", 32'(sample_mv), 0);
        check("rs_sample_slot", 32'(sample_slot), 0);
        check("rs_timeout_err", 32'(timeout_err), 0);
        check("rs_chan_err", 32'(chan_err), 0);
        for (int k = 0; k < 4; k++) check_rd(k, 0, $sformatf("rs_bank%0d", k));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        #3;
        check("rs_no_stale_sample", 32'(got_q.size()), 0);
        @(negedge clk);
        enable = 1'b1;
        wait_cmd("rs_restart");
        check("rs_restart_chan", 32'(cmd_channel), 1);
        for (int k = 0; k < 4; k++) wait_sample($sformatf("rs_s%0d", k));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
